// File: rtl/vz_pkg.sv
// Shared constants, FSM state type and filename helper for the .VZ image saver.
package vz_pkg;

  localparam logic [31:0] VZ_MAGIC      = "VZF0";
  localparam int unsigned VZ_HDR_LEN    = 24;
  localparam logic [7:0]  VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0]  VZ_TYPE_BIN   = 8'hF1;
  localparam logic [15:0] VZ_PTR_START  = 16'h78A4;
  localparam logic [15:0] VZ_PTR_END    = 16'h78F9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR,
    ST_HDR,
    ST_DATA,
    ST_FIN
  } vz_state_t;

  // A string parameter is right-justified; find its length from the highest non-NUL byte
  // so character k can be returned left-to-right with NUL padding.
  function automatic logic [7:0] name_char(input logic [127:0] nm, input int unsigned k);
    int unsigned len;
    len = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (nm[8*i +: 8] != 8'h00) len = i + 1;
    end
    if (k < len) return nm[8*(len-1-k) +: 8];
    return 8'h00;
  endfunction

endpackage

// File: rtl/vz_hdr_gen.sv
// Combinational lookup of the 24-byte .VZ header: magic, NUL-padded name, type, start address.
module vz_hdr_gen
  import vz_pkg::*;
#(
  parameter logic [127:0] NAME = "MISTER"
) (
  input  logic [4:0]  idx,
  input  logic [15:0] start_addr,
  input  logic [7:0]  typ,
  output logic [7:0]  hdr_byte
);

  always_comb begin
    hdr_byte = 8'h00;
    case (idx)
      5'd0:    hdr_byte = VZ_MAGIC[31:24];
      5'd1:    hdr_byte = VZ_MAGIC[23:16];
      5'd2:    hdr_byte = VZ_MAGIC[15:8];
      5'd3:    hdr_byte = VZ_MAGIC[7:0];
      5'd21:   hdr_byte = typ;
      5'd22:   hdr_byte = start_addr[7:0];
      5'd23:   hdr_byte = start_addr[15:8];
      default: begin
        // byte 20 is the name terminator and stays 0
        if (idx >= 5'd4 && idx <= 5'd19) hdr_byte = name_char(NAME, 32'(idx) - 32'd4);
      end
    endcase
  end

endmodule

// File: rtl/vz_image_saver.sv
// Streams the BASIC program (or, with VZ_SAVER_BIN_EN defined, a binary RAM range) as a .VZ image.
module vz_image_saver
  import vz_pkg::*;
#(
  parameter int unsigned  MEM_LAT = 1,
  parameter logic [127:0] NAME    = "MISTER"
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_din,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
`ifdef VZ_SAVER_BIN_EN
  input  logic        bin_mode,
  input  logic [15:0] bin_start,
  input  logic [15:0] bin_end,
`endif
  output logic [15:0] byte_cnt
);

  vz_state_t          state;
  logic [15:0]        start_addr, end_addr, cur_addr;
  logic [7:0]         typ;
  logic [2:0]         iss_cnt;
  logic [1:0]         cap_cnt;
  logic [4:0]         hdr_idx;
  logic               wait_rd;
  logic [MEM_LAT-1:0] rd_sr;
  logic [7:0]         hdr_byte;
  logic               hs, rd_ok;
  logic               bin_sel;
  logic [15:0]        bin_s, bin_e;

`ifdef VZ_SAVER_BIN_EN
  assign bin_sel = bin_mode;
  assign bin_s   = bin_start;
  assign bin_e   = bin_end;
`else
  assign bin_sel = 1'b0;
  assign bin_s   = '0;
  assign bin_e   = '0;
`endif

  assign hs    = out_valid & out_ready;
  assign rd_ok = rd_sr[MEM_LAT-1];

  vz_hdr_gen #(.NAME(NAME)) u_hdr (
    .idx        (hdr_idx),
    .start_addr (start_addr),
    .typ        (typ),
    .hdr_byte   (hdr_byte)
  );

  // Tracks each read strobe until its data appears on mem_din.
  always_ff @(posedge clk_sys) begin
    if (reset || abort) begin
      rd_sr <= '0;
    end else begin
      rd_sr[0] <= mem_rd;
      for (int unsigned i = 1; i < MEM_LAT; i++) rd_sr[i] <= rd_sr[i-1];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || abort) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      byte_cnt   <= '0;
      start_addr <= '0;
      end_addr   <= '0;
      cur_addr   <= '0;
      typ        <= VZ_TYPE_BASIC;
      iss_cnt    <= '0;
      cap_cnt    <= '0;
      hdr_idx    <= '0;
      wait_rd    <= 1'b0;
    end else begin
      done   <= 1'b0;
      mem_rd <= 1'b0;
      if (hs && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            byte_cnt <= '0;
            iss_cnt  <= '0;
            cap_cnt  <= '0;
            hdr_idx  <= '0;
            wait_rd  <= 1'b0;
            if (bin_sel) begin
              start_addr <= bin_s;
              end_addr   <= bin_e;
              cur_addr   <= bin_s;
              typ        <= VZ_TYPE_BIN;
              if (bin_e < bin_s) begin
                err  <= 1'b1;
                done <= 1'b1;
              end else begin
                busy  <= 1'b1;
                state <= ST_HDR;
              end
            end else begin
              typ   <= VZ_TYPE_BASIC;
              busy  <= 1'b1;
              state <= ST_PTR;
            end
          end
        end

        // The four pointer reads are issued back to back and captured in order.
        ST_PTR: begin
          if (iss_cnt < 3'd4) begin
            mem_rd   <= 1'b1;
            mem_addr <= (iss_cnt[1] ? VZ_PTR_END : VZ_PTR_START) + 16'(iss_cnt[0]);
            iss_cnt  <= iss_cnt + 3'd1;
          end
          if (rd_ok) begin
            cap_cnt <= cap_cnt + 2'd1;
            case (cap_cnt)
              2'd0: start_addr[7:0]  <= mem_din;
              2'd1: start_addr[15:8] <= mem_din;
              2'd2: end_addr[7:0]    <= mem_din;
              default: begin
                end_addr[15:8] <= mem_din;
                cur_addr       <= start_addr;
                if ({mem_din, end_addr[7:0]} < start_addr) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end else begin
                  state <= ST_HDR;
                end
              end
            endcase
          end
        end

        ST_HDR: begin
          if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FIN;
            end else if (hdr_idx == 5'(VZ_HDR_LEN)) begin
              state <= ST_DATA;
            end
          end else if (!out_valid) begin
            out_data  <= hdr_byte;
            out_valid <= 1'b1;
            out_last  <= (hdr_idx == 5'(VZ_HDR_LEN - 1)) && (end_addr == start_addr);
            hdr_idx   <= hdr_idx + 5'd1;
          end
        end

        // One byte in flight: a read is only issued once the previous byte was accepted.
        ST_DATA: begin
          if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FIN;
            end
          end else if (!out_valid && !wait_rd) begin
            mem_rd   <= 1'b1;
            mem_addr <= cur_addr;
            wait_rd  <= 1'b1;
          end
          if (rd_ok) begin
            out_data  <= mem_din;
            out_valid <= 1'b1;
            out_last  <= (cur_addr + 16'd1) == end_addr;
            cur_addr  <= cur_addr + 16'd1;
            wait_rd   <= 1'b0;
          end
        end

        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vz_image_saver.sv
// Two saver instances (MEM_LAT 1 and 3) share stimulus; accepted bytes are checked against an image model.
module tb_vz_image_saver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, out_ready;
  logic        busy [2], done [2], err [2], mem_rd [2], out_valid [2], out_last [2];
  logic [15:0] mem_addr [2], byte_cnt [2];
  logic [7:0]  mem_din [2], out_data [2];
`ifdef VZ_SAVER_BIN_EN
  logic        bin_mode;
  logic [15:0] bin_start, bin_end;
  int          rd78 [2];
`endif

  logic [7:0]  ram [65536];
  logic [7:0]  rq [2][3];

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  expq [$];
  logic        exp_err;
  logic        armed;
  int          pos [2], done_cnt [2];
  logic        prev_hold [2], prev_last [2];
  logic [7:0]  prev_data [2];
  int          ready_mode;

  vz_image_saver #(.MEM_LAT(1), .NAME("MISTER")) u0 (
    .clk_sys(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy[0]), .done(done[0]), .err(err[0]),
    .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_din(mem_din[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready), .out_last(out_last[0]),
`ifdef VZ_SAVER_BIN_EN
    .bin_mode(bin_mode), .bin_start(bin_start), .bin_end(bin_end),
`endif
    .byte_cnt(byte_cnt[0])
  );

  vz_image_saver #(.MEM_LAT(3), .NAME("MISTER")) u1 (
    .clk_sys(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy[1]), .done(done[1]), .err(err[1]),
    .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_din(mem_din[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready), .out_last(out_last[1]),
`ifdef VZ_SAVER_BIN_EN
    .bin_mode(bin_mode), .bin_start(bin_start), .bin_end(bin_end),
`endif
    .byte_cnt(byte_cnt[1])
  );

  // RAM read ports with 1 and 3 cycles of latency
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      rq[d][0] <= ram[mem_addr[d]];
      rq[d][1] <= rq[d][0];
      rq[d][2] <= rq[d][1];
    end
  end
  assign mem_din[0] = rq[0][0];
  assign mem_din[1] = rq[1][2];

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s [dut%0d]: got %0h, expected %0h", name, d, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected image from the format rules: magic, name, type, start LE, then RAM[s..e-1].
  task automatic build(input logic [15:0] s, input logic [15:0] e, input logic [7:0] typ);
    string nm;
    string mg;
    nm = "MISTER";
    mg = "VZF0";
    expq.delete();
    exp_err = (e < s);
    if (!exp_err) begin
      for (int k = 0; k < 4; k++) expq.push_back(mg[k]);
      for (int k = 0; k < 17; k++) expq.push_back(k < nm.len() ? nm[k] : 8'h00);
      expq.push_back(typ);
      expq.push_back(s[7:0]);
      expq.push_back(s[15:8]);
      for (logic [15:0] a = s; a != e; a++) expq.push_back(ram[a]);
    end
    for (int d = 0; d < 2; d++) begin
      pos[d] = 0;
      done_cnt[d] = 0;
      prev_hold[d] = 1'b0;
    end
    armed = 1'b1;
  endtask

  task automatic arm_basic(input logic [15:0] s, input logic [15:0] e);
    ram[16'h78A4] = s[7:0];
    ram[16'h78A5] = s[15:8];
    ram[16'h78F9] = e[7:0];
    ram[16'h78FA] = e[15:8];
    build(s, e, 8'hF0);
  endtask

  task automatic go(input int bound, input bit extra_start);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt[0] > 0 && done_cnt[1] > 0) break;
      start = extra_start && (i == 10);
      tick(1);
    end
    start = 1'b0;
    tick(3);
    for (int d = 0; d < 2; d++) begin
      chk("done_pulses", d, done_cnt[d], 1);
      chk("idle_after", d, busy[d], 0);
    end
  endtask

  task automatic zero_check(input string name);
    for (int d = 0; d < 2; d++)
      chk(name, d, {busy[d], done[d], err[d], mem_rd[d], out_valid[d], out_last[d],
                    out_data[d], mem_addr[d], byte_cnt[d]}, 64'd0);
  endtask

  // Compare process: every accepted byte, hold stability, read discipline and done.
  always @(negedge clk) begin
    if (!reset && armed) begin
      for (int d = 0; d < 2; d++) begin
        if (prev_hold[d]) begin
          chk("hold_valid", d, out_valid[d], 1);
          chk("hold_data", d, out_data[d], prev_data[d]);
          chk("hold_last", d, out_last[d], prev_last[d]);
        end
        if (mem_rd[d]) chk("rd_while_valid", d, out_valid[d], 0);
        if (out_valid[d] && expq.size() == 0) chk("valid_on_err", d, out_valid[d], 0);
        if (out_valid[d] && out_ready) begin
          if (pos[d] < expq.size()) begin
            chk("data", d, out_data[d], expq[pos[d]]);
            chk("last", d, out_last[d], pos[d] == expq.size() - 1);
            chk("byte_cnt", d, byte_cnt[d], pos[d]);
          end else begin
            chk("extra_bytes", d, pos[d] + 1, expq.size());
          end
          pos[d]++;
        end
        if (done[d]) begin
          done_cnt[d]++;
          chk("done_bytes", d, pos[d], expq.size());
          chk("done_err", d, err[d], exp_err);
          chk("done_busy", d, busy[d], 0);
        end
        prev_hold[d] = out_valid[d] && !out_ready;
        prev_data[d] = out_data[d];
        prev_last[d] = out_last[d];
      end
    end
  end

`ifdef VZ_SAVER_BIN_EN
  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (mem_rd[d] && mem_addr[d][15:8] == 8'h78) rd78[d]++;
`endif

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc0, cyc1;
    logic [15:0] s, e;
    reset = 1'b1; start = 1'b0; abort = 1'b0; armed = 1'b0; ready_mode = 0;
`ifdef VZ_SAVER_BIN_EN
    bin_mode = 1'b0; bin_start = '0; bin_end = '0;
`endif
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    tick(3);
    zero_check("reset_state");
    reset = 1'b0;
    tick(2);

    // 1: BASIC program 7AE9..7AEF, sink always ready
    arm_basic(16'h7AE9, 16'h7AF0);
    chk("model_len", 0, expq.size(), 31);
    chk("model_b0", 0, expq[0], 8'h56);
    chk("model_b4", 0, expq[4], 8'h4D);
    chk("model_b20", 0, expq[20], 8'h00);
    chk("model_b21", 0, expq[21], 8'hF0);
    chk("model_b22", 0, expq[22], 8'hE9);
    chk("model_b23", 0, expq[23], 8'h7A);
    go(2000, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk("t1_byte_cnt", d, byte_cnt[d], 16'd31);
      chk("t1_err", d, err[d], 0);
    end

    // 2: same image, 30% ready, plus a start pulse while busy
    ready_mode = 1;
    arm_basic(16'h7AE9, 16'h7AF0);
    go(4000, 1'b1);
    ready_mode = 0;

    // 4: end < start
    arm_basic(16'h7AE9, 16'h7AE0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc0 = 0; cyc1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy[0] && !busy[1]) break;
      if (busy[0]) cyc0++;
      if (busy[1]) cyc1++;
      tick(1);
    end
    chk("err_fast_lat1", 0, cyc0 < 8, 1);
    chk("err_fast_lat3", 1, cyc1 < 12, 1);
    tick(3);
    for (int d = 0; d < 2; d++) begin
      chk("err_done_pulses", d, done_cnt[d], 1);
      chk("err_sticky", d, err[d], 1);
    end

    // 3: end == start -> header only (also clears err)
    arm_basic(16'h7AE9, 16'h7AE9);
    chk("model_hdr_only", 0, expq.size(), 24);
    go(2000, 1'b0);

    // 16-bit wrap: start FFFF, end 0000 is an error
    arm_basic(16'hFFFF, 16'h0000);
    go(200, 1'b0);

    // 5: reset then abort at data byte 5, then a full image
    for (int v = 0; v < 2; v++) begin
      arm_basic(16'h7AE9, 16'h7AF0);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int i = 0; i < 500 && pos[0] < 29; i++) tick(1);
      chk("reached_byte5", 0, pos[0] >= 29, 1);
      armed = 1'b0;
      if (v == 0) reset = 1'b1; else abort = 1'b1;
      tick(1);
      reset = 1'b0;
      abort = 1'b0;
      zero_check(v == 0 ? "reset_mid" : "abort_mid");
      tick(3);
      zero_check(v == 0 ? "reset_quiet" : "abort_quiet");
      arm_basic(16'h7AE9, 16'h7AF0);
      go(2000, 1'b0);
    end

    // start and abort together in IDLE: abort wins
    armed = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    tick(2);
    for (int d = 0; d < 2; d++) chk("abort_wins", d, {busy[d], mem_rd[d]}, 2'b00);

    // randomized ranges, ready pattern and occasional end < start
    for (int r = 0; r < 8; r++) begin
      ready_mode = $urandom_range(0, 1);
      s = 16'h9000 + 16'($urandom_range(0, 255));
      e = ($urandom_range(0, 3) == 0) ? s - 16'($urandom_range(1, 5))
                                      : s + 16'($urandom_range(0, 40));
      arm_basic(s, e);
      go(6000, 1'b0);
    end
    ready_mode = 0;

`ifdef VZ_SAVER_BIN_EN
    // 6: binary range 8000..8003
    bin_mode = 1'b1; bin_start = 16'h8000; bin_end = 16'h8004;
    rd78[0] = 0; rd78[1] = 0;
    build(16'h8000, 16'h8004, 8'hF1);
    chk("model_bin_len", 0, expq.size(), 28);
    chk("model_bin_b21", 0, expq[21], 8'hF1);
    chk("model_bin_b23", 0, expq[23], 8'h80);
    go(2000, 1'b0);
    for (int d = 0; d < 2; d++) chk("bin_no_ptr_reads", d, rd78[d], 0);
    bin_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
